// File: rtl/rv32i_types.sv
// Shared types for the memory-side arbitration logic.
// Holds the arbiter FSM state and grant-side encodings.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one shared memory port.
// Non-preemptive; simultaneous requests alternate by granting the side not served last.
module cache_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
);

    import rv32i_types::*;

    arb_state_t state_q, state_d;
    arb_grant_t last_grant_q;
    arb_grant_t grant_side;
    logic       grant_valid;
    logic       conflict;
    logic       d_req;

    logic [31:0] perf_i_q, perf_d_q, perf_c_q;

    assign d_req = d_read | d_write;

    // State register plus everything that only changes on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            perf_i_q     <= 32'd0;
            perf_d_q     <= 32'd0;
            perf_c_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (grant_valid) begin
                last_grant_q <= grant_side;
                if (grant_side == GRANT_I) begin
                    perf_i_q <= perf_i_q + 32'd1;
                end else begin
                    perf_d_q <= perf_d_q + 32'd1;
                end
            end
            if (conflict) begin
                perf_c_q <= perf_c_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_side  = GRANT_I;
        conflict    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_read && d_req) begin
                    conflict    = 1'b1;
                    grant_valid = 1'b1;
                    grant_side  = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
                end else if (i_read) begin
                    grant_valid = 1'b1;
                    grant_side  = GRANT_I;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_side  = GRANT_D;
                end
                if (grant_valid) begin
                    state_d = (grant_side == GRANT_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                // Grant holds until memory completes, whatever the other side does.
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Commands depend only on registered state, so nothing is issued from IDLE.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state_q)
            SERVE_I: begin
                pmem_read = 1'b1;
                pmem_addr = i_addr;
                i_resp    = pmem_resp;
            end
            SERVE_D: begin
                pmem_read  = d_read;
                pmem_write = d_write;
                pmem_addr  = d_addr;
                pmem_wdata = d_wdata;
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    assign perf_i_grants  = perf_i_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_c_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grants, alternation, reset abandonment, stray responses.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cache_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read, d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [31:0]       perf_i_grants, perf_d_grants, perf_conflicts;

    int total = 0;
    int bad   = 0;

    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_WB = {8{32'hDEAD_BEEF}};

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_read         (i_read),
        .i_addr         (i_addr),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_addr      (pmem_addr),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_read = 1'b1; i_addr = 32'h40;
        do_reset();
        i_read = 1'b0;
        #1;
        total++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            $display("FAIL reset_cmd got=%b want=00", {pmem_read, pmem_write}); bad++;
        end
        total++;
        if (pmem_addr !== 32'h0) begin
            $display("FAIL reset_addr got=%h want=0", pmem_addr); bad++;
        end
        total++;
        if ({perf_i_grants, perf_d_grants, perf_conflicts} !== 96'h0) begin
            $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0",
                     perf_i_grants, perf_d_grants, perf_conflicts); bad++;
        end
        total++;
        if ({i_resp, d_resp} !== 2'b00) begin
            $display("FAIL reset_resp got=%b want=00", {i_resp, d_resp}); bad++;
        end
    endtask

    task automatic test_lone_i();
        clear_inputs();
        do_reset();
        i_read = 1'b1; i_addr = 32'h0000_0060;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 32'h60) begin
                $display("FAIL lone_i_cmd cyc=%0d got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=60",
                         c, pmem_read, pmem_write, pmem_addr); bad++;
            end
            total++;
            if (i_resp !== 1'b0) begin
                $display("FAIL lone_i_early_resp cyc=%0d got=%b want=0", c, i_resp); bad++;
            end
        end
        step();
        pmem_resp = 1'b1; pmem_rdata = PAT_A5;
        #1;
        total++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
            $display("FAIL lone_i_resp got i=%b d=%b want i=1 d=0", i_resp, d_resp); bad++;
        end
        total++;
        if (i_rdata !== PAT_A5 || pmem_read !== 1'b1) begin
            $display("FAIL lone_i_rdata got=%h rd=%b want=%h rd=1", i_rdata, pmem_read, PAT_A5);
            bad++;
        end
        step();
        i_read = 1'b0; pmem_resp = 1'b0;
        #1;
        total++;
        if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
            $display("FAIL lone_i_done got rd=%b resp=%b want 0 0", pmem_read, i_resp); bad++;
        end
        total++;
        if (perf_i_grants !== 32'd1 || perf_d_grants !== 32'd0 || perf_conflicts !== 32'd0) begin
            $display("FAIL lone_i_counters got=%0d/%0d/%0d want=1/0/0",
                     perf_i_grants, perf_d_grants, perf_conflicts); bad++;
        end
    endtask

    task automatic test_conflict();
        clear_inputs();
        do_reset();
        i_read = 1'b1; i_addr = 32'h200;
        d_write = 1'b1; d_addr = 32'h100; d_wdata = PAT_WB;
        step();
        total++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h100 ||
            pmem_wdata !== PAT_WB) begin
            $display("FAIL conflict_d_first got rd=%b wr=%b addr=%h want rd=0 wr=1 addr=100",
                     pmem_read, pmem_write, pmem_addr); bad++;
        end
        total++;
        if (perf_conflicts !== 32'd1 || perf_d_grants !== 32'd1 || perf_i_grants !== 32'd0) begin
            $display("FAIL conflict_counters1 got=%0d/%0d/%0d want=0/1/1",
                     perf_i_grants, perf_d_grants, perf_conflicts); bad++;
        end
        pmem_resp = 1'b1;
        #1;
        total++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            $display("FAIL conflict_d_resp got d=%b i=%b want d=1 i=0", d_resp, i_resp); bad++;
        end
        step();
        d_write = 1'b0; pmem_resp = 1'b0;
        #1;
        total++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_addr !== 32'h0) begin
            $display("FAIL conflict_idle_gap got rd=%b wr=%b addr=%h want 0 0 0",
                     pmem_read, pmem_write, pmem_addr); bad++;
        end
        step();
        total++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h200 || pmem_wdata !== '0) begin
            $display("FAIL conflict_i_second got rd=%b addr=%h want rd=1 addr=200",
                     pmem_read, pmem_addr); bad++;
        end
        pmem_resp = 1'b1;
        step();
        i_read = 1'b0; pmem_resp = 1'b0;
        total++;
        if (perf_i_grants !== 32'd1 || perf_d_grants !== 32'd1 || perf_conflicts !== 32'd1) begin
            $display("FAIL conflict_counters2 got=%0d/%0d/%0d want=1/1/1",
                     perf_i_grants, perf_d_grants, perf_conflicts); bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] want_addr [3];
        want_addr[0] = 32'h80; want_addr[1] = 32'h40; want_addr[2] = 32'h80;
        clear_inputs();
        do_reset();
        i_read = 1'b1; i_addr = 32'h40;
        d_read = 1'b1; d_addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (pmem_read !== 1'b1 || pmem_addr !== want_addr[k]) begin
                $display("FAIL b2b_order k=%0d got rd=%b addr=%h want rd=1 addr=%h",
                         k, pmem_read, pmem_addr, want_addr[k]); bad++;
            end
            pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
            if (k == 2) begin
                i_read = 1'b0; d_read = 1'b0;
            end
            #1;
            total++;
            if (pmem_read !== 1'b0) begin
                $display("FAIL b2b_idle k=%0d got rd=%b want 0", k, pmem_read); bad++;
            end
        end
        step();
        total++;
        if (perf_conflicts !== 32'd3 || perf_i_grants !== 32'd1 || perf_d_grants !== 32'd2) begin
            $display("FAIL b2b_counters got=%0d/%0d/%0d want=1/2/3",
                     perf_i_grants, perf_d_grants, perf_conflicts); bad++;
        end
    endtask

    // Runs after test_back_to_back with counters at 1/2/3.
    task automatic test_idle_resp();
        pmem_resp = 1'b1; pmem_rdata = PAT_A5;
        #1;
        total++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            $display("FAIL idle_resp_out got i=%b d=%b want 0 0", i_resp, d_resp); bad++;
        end
        step();
        pmem_resp = 1'b0;
        step();
        total++;
        if (pmem_read !== 1'b0 || perf_conflicts !== 32'd3 || perf_i_grants !== 32'd1 ||
            perf_d_grants !== 32'd2) begin
            $display("FAIL idle_resp_state got rd=%b cnt=%0d/%0d/%0d want rd=0 cnt=1/2/3",
                     pmem_read, perf_i_grants, perf_d_grants, perf_conflicts); bad++;
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        do_reset();
        d_read = 1'b1; d_addr = 32'h300;
        step();
        total++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h300 || perf_d_grants !== 32'd1) begin
            $display("FAIL rmid_grant got rd=%b addr=%h dg=%0d want rd=1 addr=300 dg=1",
                     pmem_read, pmem_addr, perf_d_grants); bad++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0; d_read = 1'b0;
        #1;
        total++;
        if (pmem_read !== 1'b0 || pmem_addr !== 32'h0 ||
            {perf_i_grants, perf_d_grants, perf_conflicts} !== 96'h0) begin
            $display("FAIL rmid_cleared got rd=%b addr=%h dg=%0d want rd=0 addr=0 dg=0",
                     pmem_read, pmem_addr, perf_d_grants); bad++;
        end
        step();
        pmem_resp = 1'b1;
        #1;
        total++;
        if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
            $display("FAIL rmid_late_resp got d=%b i=%b want 0 0", d_resp, i_resp); bad++;
        end
        step();
        pmem_resp = 1'b0;
        step();
        total++;
        if (pmem_read !== 1'b0 || {perf_i_grants, perf_d_grants, perf_conflicts} !== 96'h0) begin
            $display("FAIL rmid_after got rd=%b cnt=%0d/%0d/%0d want rd=0 cnt=0/0/0",
                     pmem_read, perf_i_grants, perf_d_grants, perf_conflicts); bad++;
        end
    endtask

    task automatic test_hold_d();
        clear_inputs();
        do_reset();
        i_read = 1'b1; i_addr = 32'h40;
        step();
        d_read = 1'b1; d_addr = 32'h80;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (pmem_addr !== 32'h40 || pmem_read !== 1'b1 || d_resp !== 1'b0) begin
                $display("FAIL hold_d_no_preempt cyc=%0d got addr=%h rd=%b dresp=%b want 40 1 0",
                         c, pmem_addr, pmem_read, d_resp); bad++;
            end
        end
        pmem_resp = 1'b1;
        #1;
        total++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
            $display("FAIL hold_d_i_resp got i=%b d=%b want i=1 d=0", i_resp, d_resp); bad++;
        end
        step();
        i_read = 1'b0; pmem_resp = 1'b0;
        #1;
        total++;
        if (pmem_read !== 1'b0 || pmem_addr !== 32'h0) begin
            $display("FAIL hold_d_gap got rd=%b addr=%h want 0 0", pmem_read, pmem_addr); bad++;
        end
        step();
        total++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h80 || perf_d_grants !== 32'd1 ||
            perf_conflicts !== 32'd0) begin
            $display("FAIL hold_d_grant got rd=%b addr=%h dg=%0d cf=%0d want 1 80 1 0",
                     pmem_read, pmem_addr, perf_d_grants, perf_conflicts); bad++;
        end
        pmem_resp = 1'b1;
        step();
        d_read = 1'b0; pmem_resp = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_lone_i();
        test_conflict();
        test_back_to_back();
        test_idle_resp();
        test_reset_mid();
        test_hold_d();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_W, 256, cacheline width in bits.
REQ-002 Parameter: ADDR_W, 32, address width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_read  input  1  I-cache line-fill request.
REQ-006 i_addr  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  fill data to I-cache.
REQ-008 i_resp  output  1  I-cache transaction complete.
REQ-009 d_read, d_write  input  1 each  D-cache fill / writeback request; never both high.
REQ-010 d_addr  input  ADDR_W  D-cache line address.
REQ-011 d_wdata  input  LINE_W  D-cache writeback data.
REQ-012 d_rdata  output  LINE_W  fill data to D-cache.
REQ-013 d_resp  output  1  D-cache transaction complete.
REQ-014 pmem_read, pmem_write  output  1 each  shared-memory command.
REQ-015 pmem_addr  output  ADDR_W;  pmem_wdata  output  LINE_W.
REQ-016 pmem_rdata  input  LINE_W;  pmem_resp  input  1  memory completion.
REQ-017 perf_i_grants, perf_d_grants, perf_conflicts  output  32 each  performance counters.

Function
REQ-018 FSM states SHALL be IDLE, SERVE_I, SERVE_D.
REQ-019 IDLE: no requests -> stay IDLE; only i_read -> SERVE_I; only d_read|d_write -> SERVE_D.
REQ-020 IDLE, both sides requesting: grant the side NOT recorded in last_grant; the recorded side waits; perf_conflicts increments by 1.
REQ-021 last_grant SHALL update on every grant (I or D) and SHALL reset to I, so first conflict after reset grants D.
REQ-022 pmem_read/pmem_write SHALL be functions of the registered state only: SERVE_I -> pmem_read=1; SERVE_D -> pmem_read=d_read, pmem_write=d_write; IDLE -> both 0.
REQ-023 pmem_addr/pmem_wdata SHALL mux from the granted side; in IDLE they SHALL be 0.
REQ-024 Request sampled in IDLE at edge N -> pmem command high from cycle N+1 until and including the pmem_resp cycle.
REQ-025 i_rdata = d_rdata = pmem_rdata (combinational pass-through, unqualified).
REQ-026 i_resp = pmem_resp & (state==SERVE_I); d_resp = pmem_resp & (state==SERVE_D); no responses in IDLE.
REQ-027 On pmem_resp in SERVE_I or SERVE_D the FSM SHALL return to IDLE; minimum one IDLE cycle between consecutive grants.
REQ-028 A requester SHALL NOT be preempted; the grant holds until pmem_resp regardless of the other side.
REQ-029 pmem_resp arriving in IDLE SHALL be ignored (no state change, no resp output).
REQ-030 A request deasserted before grant SHALL be dropped with no pmem activity.
REQ-031 perf_i_grants / perf_d_grants SHALL increment by 1 on each IDLE->SERVE_I / IDLE->SERVE_D transition; all counters wrap at 2^32 without saturation.

Reset
REQ-032 rst SHALL force state=IDLE, last_grant=I, all counters=0, all pmem command outputs=0 in the following cycle.
REQ-033 rst mid-transaction SHALL abandon it: no i_resp/d_resp issued, and a late pmem_resp after reset is ignored per REQ-029.

Structure
REQ-034 State enum (arb_state_t) and grant enum (arb_grant_t: GRANT_I, GRANT_D) SHALL live in the shared rv32i_types package.
REQ-035 Implementation SHALL be a single module; no sub-modules.

Verification
REQ-036 Lone I fill: i_read, i_addr=0x0000_0060, pmem_resp after 5 cycles with rdata=0xA5..A5 -> pmem_read/pmem_addr=0x60 from cycle 1, i_resp one cycle, i_rdata=0xA5..A5, d_resp=0, perf_i_grants=1.
REQ-037 Simultaneous i_read and d_write (d_addr=0x100) after reset -> D served first (pmem_write, addr=0x100), then IDLE one cycle, then I served; perf_conflicts=1, both grant counters=1.
REQ-038 Three back-to-back conflicts -> grant order D, I, D; perf_conflicts=3.
REQ-039 rst asserted in SERVE_D, pmem_resp two cycles later -> no d_resp, state IDLE, all counters 0.
REQ-040 pmem_resp pulsed while IDLE with no requests -> no i_resp/d_resp, counters unchanged.
REQ-041 d_read held while the I fill completes -> D granted on the edge after the post-resp IDLE cycle, never during the I transaction.
